// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, accumulator state encoding and output saturation.
package cnn_pkg;
  localparam int PRODUCT_WIDTH = 16;
  localparam int ACC_WIDTH = 24;
  localparam int OUT_WIDTH = 8;
  typedef enum logic [1:0] {ACC, POST, OUT} state_t;
  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] v);
    logic signed [ACC_WIDTH:0] hi, lo;
    hi = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    lo = ~hi;
    return v > hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
           v < lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : v[OUT_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/requant_unit.sv
// requant_unit: bias add, optional ReLU, arithmetic right shift and signed saturation.
module requant_unit import cnn_pkg::*; #(
  parameter int BIAS_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic        [4:0]            shift,
  input  logic                         relu_en,
  output logic signed [OUT_WIDTH-1:0]  res
);
  logic signed [ACC_WIDTH:0] sum, pos, shifted;
  // One extra bit so the bias add can never wrap.
  assign sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(bias);
  assign pos = (relu_en && sum[ACC_WIDTH]) ? '0 : sum;
  assign shifted = pos >>> shift;
  assign res = saturate(shifted);
endmodule

// File: rtl/pe_accumulator.sv
// pe_accumulator: sums KERNEL_LEN signed PE products per pixel and emits a requantized
// 8-bit activation over a valid/ready handshake.
module pe_accumulator #(
  parameter int PRODUCT_WIDTH = cnn_pkg::PRODUCT_WIDTH,
  parameter int ACC_WIDTH     = cnn_pkg::ACC_WIDTH,
  parameter int BIAS_WIDTH    = 16,
  parameter int OUT_WIDTH     = cnn_pkg::OUT_WIDTH,
  parameter int KERNEL_LEN    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [PRODUCT_WIDTH-1:0] product_input,
  input  logic                         product_valid,
  output logic                         product_ready,
  input  logic signed [BIAS_WIDTH-1:0] bias_input,
  input  logic        [4:0]            shift_amt,
  input  logic                         relu_en,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);
  import cnn_pkg::*;
  localparam int CW = KERNEL_LEN > 1 ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(KERNEL_LEN - 1);
  if (KERNEL_LEN < 1) begin : g_len_chk
    $error("KERNEL_LEN must be at least 1");
  end
  if (ACC_WIDTH < PRODUCT_WIDTH + $clog2(KERNEL_LEN)) begin : g_acc_chk
    $error("ACC_WIDTH too narrow for KERNEL_LEN products");
  end
  // The requant path is built at the package widths.
  if (ACC_WIDTH != cnn_pkg::ACC_WIDTH || OUT_WIDTH != cnn_pkg::OUT_WIDTH || BIAS_WIDTH > ACC_WIDTH) begin : g_pkg_chk
    $error("ACC_WIDTH/OUT_WIDTH must match cnn_pkg and BIAS_WIDTH must fit the accumulator");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_x;
  logic signed [BIAS_WIDTH-1:0] bias_q, bias_d;
  logic [4:0] shift_q, shift_d;
  logic relu_q, relu_d;
  logic signed [OUT_WIDTH-1:0] out_q, out_d, req;
  logic accept, first;
  assign product_ready = state_q == ACC;
  assign out_valid = state_q == OUT;
  assign out_data = out_q;
  assign accept = product_valid && product_ready;
  assign first = cnt_q == '0;
  assign prod_x = ACC_WIDTH'(product_input);
  always_comb begin
    state_d = state_q == ACC  ? ((accept && cnt_q == LAST) ? POST : ACC) :
              state_q == POST ? OUT : (out_ready ? ACC : OUT);
    cnt_d = accept ? (cnt_q == LAST ? '0 : cnt_q + CW'(1)) : cnt_q;
    acc_d = accept ? (first ? prod_x : acc_q + prod_x) : acc_q;
    bias_d = (accept && first) ? bias_input : bias_q;
    shift_d = (accept && first) ? shift_amt : shift_q;
    relu_d = (accept && first) ? relu_en : relu_q;
    out_d = state_q == POST ? req : out_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q <= '0;
      acc_q <= '0;
      bias_q <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      bias_q <= bias_d;
      shift_q <= shift_d;
      relu_q <= relu_d;
      out_q <= out_d;
    end
  end
  requant_unit #(.BIAS_WIDTH(BIAS_WIDTH)) u_requant (
    .acc(acc_q),
    .bias(bias_q),
    .shift(shift_q),
    .relu_en(relu_q),
    .res(req)
  );
endmodule

// File: tb/tb_pe_accumulator.sv
// tb_pe_accumulator: directed vector table plus backpressure, async reset and gapped-valid sequences.
module tb_pe_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] product_input;
  logic product_valid, product_ready;
  logic signed [15:0] bias_input;
  logic [4:0] shift_amt;
  logic relu_en;
  logic signed [7:0] out_data;
  logic out_valid, out_ready;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int base;
    int inc;
    int bias;
    int shift;
    bit relu;
    bit gapped;
    int exp;
    string name;
  } vec_t;
  vec_t vecs[10];

  pe_accumulator dut (
    .clk(clk),
    .rst_n(rst_n),
    .product_input(product_input),
    .product_valid(product_valid),
    .product_ready(product_ready),
    .bias_input(bias_input),
    .shift_amt(shift_amt),
    .relu_en(relu_en),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Window parameters are driven only with the first product; later beats carry junk
  // so that a design which fails to latch them is caught.
  task automatic run_window(input vec_t v);
    for (int i = 0; i < 9; i++) begin
      if (v.gapped) begin
        product_valid = 1'b0;
        product_input = 16'sh7fff;
        step();
      end
      product_valid = 1'b1;
      product_input = 16'(v.base + i * v.inc);
      bias_input = (i == 0) ? 16'(v.bias) : 16'sh1234;
      shift_amt = (i == 0) ? 5'(v.shift) : 5'd3;
      relu_en = (i == 0) ? v.relu : ~v.relu;
      step();
    end
    product_valid = 1'b0;
    product_input = 16'sh5555;
    chk({v.name, "_post_valid"}, int'(out_valid), 0);
    chk({v.name, "_post_ready"}, int'(product_ready), 0);
    step();
    chk({v.name, "_valid"}, int'(out_valid), 1);
    chk({v.name, "_data"}, int'(out_data), v.exp);
    if (out_ready) begin
      step();
      chk({v.name, "_valid_drop"}, int'(out_valid), 0);
      chk({v.name, "_ready_back"}, int'(product_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t bp;
    vecs[0] = '{10, 0, 0, 0, 1'b1, 1'b0, 90, "basic"};
    vecs[1] = '{-20, 0, 0, 0, 1'b1, 1'b0, 0, "relu_neg"};
    vecs[2] = '{-20, 0, 0, 0, 1'b0, 1'b0, -128, "sat_neg"};
    vecs[3] = '{1000, 0, -8, 4, 1'b0, 1'b0, 127, "sat_pos"};
    vecs[4] = '{1000, 0, -8, 7, 1'b0, 1'b0, 70, "shift7"};
    vecs[5] = '{10, 0, 100, 1, 1'b0, 1'b0, 95, "bias_shift"};
    vecs[6] = '{-20, 0, 0, 31, 1'b0, 1'b0, -1, "shift31_neg"};
    vecs[7] = '{10, 0, 0, 31, 1'b0, 1'b0, 0, "shift31_pos"};
    vecs[8] = '{-32768, 0, 0, 16, 1'b0, 1'b0, -5, "min_prod"};
    vecs[9] = '{-3, 0, 0, 0, 1'b0, 1'b1, -27, "gapped"};
    product_valid = 1'b0;
    product_input = '0;
    bias_input = '0;
    shift_amt = '0;
    relu_en = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ready", int'(product_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run_window(vecs[i]);
    // Backpressure: result held while products are offered but refused.
    out_ready = 1'b0;
    bp = '{1, 1, 5, 0, 1'b0, 1'b0, 50, "bp"};
    run_window(bp);
    for (int i = 0; i < 5; i++) begin
      product_valid = 1'b1;
      product_input = 16'sd100;
      step();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(out_data), 50);
      chk("bp_hold_ready", int'(product_ready), 0);
    end
    product_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", int'(out_valid), 0);
    run_window(vecs[0]);
    // Reset mid-window, asserted between clock edges.
    for (int i = 0; i < 4; i++) begin
      product_valid = 1'b1;
      product_input = 16'sd7;
      bias_input = '0;
      shift_amt = '0;
      relu_en = 1'b0;
      step();
    end
    product_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ready", int'(product_ready), 1);
    #1 rst_n = 1'b1;
    step();
    bp = '{1, 0, 0, 0, 1'b0, 1'b0, 9, "after_rst"};
    run_window(bp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
